// File: rtl/tiny_cpu.sv
// tiny_cpu: single-issue RV32I-subset core for the demo board.
// The board clock is divided down to slow_clk. One instruction retires on
// each slow_clk rising edge. The program is held in a fixed 16-word ROM.
// The core has a 32x32 register file and a small word-addressed data RAM.
//   CLK       in   board clock (the only clock; slow_clk is a derived enable)
//   RST       in   asynchronous active-high reset
//   led_red   out  R[1][0]
//   led_green out  R[2][0]
//   led_blue  out  R[3][0]
module tiny_cpu #(
    parameter int SLOW_DIV   = 2,
    parameter int DMEM_WORDS = 16
) (
    input  logic CLK,
    input  logic RST,
    output logic led_red,
    output logic led_green,
    output logic led_blue
);
    localparam int CW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam int AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    logic [CW-1:0] r_div_cnt;
    logic          slow_clk;
    logic [31:0]   PC;
    logic [31:0]   IR;
    logic [31:0]   R [0:31];
    logic [31:0]   r_dmem [0:DMEM_WORDS-1];

    function automatic logic [31:0] rom_word(input logic [3:0] idx);
        case (idx)
            4'd0:    rom_word = 32'h00500093; // ADDI x1,x0,5
            4'd1:    rom_word = 32'h00300113; // ADDI x2,x0,3
            4'd2:    rom_word = 32'h002081B3; // ADD  x3,x1,x2
            4'd3:    rom_word = 32'h40108233; // SUB  x4,x1,x1
            4'd4:    rom_word = 32'h00118293; // ADDI x5,x3,1
            4'd5:    rom_word = 32'h02A00313; // ADDI x6,x0,42
            4'd6:    rom_word = 32'h00000393; // ADDI x7,x0,0
            4'd7:    rom_word = 32'h0063A023; // SW   x6,0(x7)
            4'd8:    rom_word = 32'h0003A403; // LW   x8,0(x7)
            4'd9:    rom_word = 32'h000404B3; // ADD  x9,x8,x0
            4'd10:   rom_word = 32'h0000006F; // JAL  x0,0
            default: rom_word = 32'h00000013; // NOP
        endcase
    endfunction

    // The commit strobe is the CLK cycle on which slow_clk goes 0 -> 1.
    // This keeps all state in the CLK domain.
    logic w_div_wrap, w_tick;
    assign w_div_wrap = (r_div_cnt == CW'(SLOW_DIV - 1));
    assign w_tick     = w_div_wrap && !slow_clk;

    // Decode fields
    logic [6:0]  w_op, w_f7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic [31:0] w_a, w_b, w_imm_i, w_imm_s, w_imm_j;
    logic [AW-1:0] w_ld_idx, w_st_idx;

    assign w_op  = IR[6:0];
    assign w_rd  = IR[11:7];
    assign w_f3  = IR[14:12];
    assign w_rs1 = IR[19:15];
    assign w_rs2 = IR[24:20];
    assign w_f7  = IR[31:25];
    assign w_a   = R[w_rs1];   // R[0] is never written, so it always reads 0
    assign w_b   = R[w_rs2];

    assign w_imm_i = {{20{IR[31]}}, IR[31:20]};
    assign w_imm_s = {{20{IR[31]}}, IR[31:25], IR[11:7]};
    assign w_imm_j = {{11{IR[31]}}, IR[31], IR[19:12], IR[20], IR[30:21], 1'b0};

    // Word index. Dropping the byte bits and truncating gives wrap-around.
    assign w_ld_idx = AW'((w_a + w_imm_i) >> 2);
    assign w_st_idx = AW'((w_a + w_imm_s) >> 2);

    logic        w_we, w_st;
    logic [31:0] w_wdata, w_next_pc;

    always_comb begin
        w_we      = 1'b0;
        w_st      = 1'b0;
        w_wdata   = 32'h0;
        w_next_pc = PC + 32'd4;
        case (w_op)
            7'b0110011: begin
                w_we = 1'b1;
                case ({w_f7, w_f3})
                    10'b0000000_000: w_wdata = w_a + w_b;
                    10'b0100000_000: w_wdata = w_a - w_b;
                    10'b0000000_111: w_wdata = w_a & w_b;
                    10'b0000000_110: w_wdata = w_a | w_b;
                    10'b0000000_100: w_wdata = w_a ^ w_b;
                    10'b0000000_010: w_wdata = {31'h0, $signed(w_a) < $signed(w_b)};
                    default:         w_we    = 1'b0;
                endcase
            end
            7'b0010011: if (w_f3 == 3'b000) begin
                w_we    = 1'b1;
                w_wdata = w_a + w_imm_i;
            end
            7'b0000011: if (w_f3 == 3'b010) begin
                w_we    = 1'b1;
                w_wdata = r_dmem[w_ld_idx];
            end
            7'b0100011: if (w_f3 == 3'b010) w_st = 1'b1;
            7'b1101111: begin
                w_we      = 1'b1;
                w_wdata   = PC + 32'd4;
                w_next_pc = PC + w_imm_j;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_div_cnt <= '0;
            slow_clk  <= 1'b0;
            PC        <= 32'h0;
            IR        <= rom_word(4'd0);
            for (int i = 0; i < 32; i++) R[i] <= 32'h0;
        end else begin
            if (w_div_wrap) begin
                r_div_cnt <= '0;
                slow_clk  <= ~slow_clk;
            end else begin
                r_div_cnt <= r_div_cnt + CW'(1);
            end
            if (w_tick) begin
                PC <= w_next_pc;
                IR <= rom_word(w_next_pc[5:2]);
                if (w_we && (w_rd != 5'd0)) R[w_rd] <= w_wdata;
            end
        end
    end

    // Data RAM keeps its contents across reset.
    always_ff @(posedge CLK) begin
        if (w_tick && w_st) r_dmem[w_st_idx] <= w_b;
    end

    assign led_red   = R[1][0];
    assign led_green = R[2][0];
    assign led_blue  = R[3][0];
endmodule

// File: tb/tb_tiny_cpu.sv
module tb_tiny_cpu;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic led_r, led_g, led_b;
    logic l5_r, l5_g, l5_b;

    always #5 CLK = ~CLK;

    tiny_cpu #(.SLOW_DIV(2), .DMEM_WORDS(16)) dut (
        .CLK(CLK), .RST(RST), .led_red(led_r), .led_green(led_g), .led_blue(led_b));
    tiny_cpu #(.SLOW_DIV(5), .DMEM_WORDS(16)) dut5 (
        .CLK(CLK), .RST(RST), .led_red(l5_r), .led_green(l5_g), .led_blue(l5_b));

    int total = 0, passed = 0, fails = 0;

    // Reference model: an instruction-set-level interpreter over plain arrays
    logic [31:0] rom_m [16];
    logic [31:0] mR [32];
    logic [31:0] mdm [16];
    logic [31:0] mPC;

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
    endfunction
    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        return ((imm & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        return (((imm >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
               | ((imm & 32'h1f) << 7) | 32'h23;
    endfunction

    function automatic void build_rom();
        for (int i = 0; i < 16; i++) rom_m[i] = 32'h00000013;
        rom_m[0]  = enc_i(5, 0, 0, 1, 'h13);
        rom_m[1]  = enc_i(3, 0, 0, 2, 'h13);
        rom_m[2]  = enc_r(0, 2, 1, 0, 3);
        rom_m[3]  = enc_r('h20, 1, 1, 0, 4);
        rom_m[4]  = enc_i(1, 3, 0, 5, 'h13);
        rom_m[5]  = enc_i(42, 0, 0, 6, 'h13);
        rom_m[6]  = enc_i(0, 0, 0, 7, 'h13);
        rom_m[7]  = enc_s(0, 6, 7);
        rom_m[8]  = enc_i(0, 7, 2, 8, 'h03);
        rom_m[9]  = enc_r(0, 0, 8, 0, 9);
        rom_m[10] = 32'h0000006F;
    endfunction

    function automatic int sx(logic [31:0] v, int bits);
        return int'(v << (32 - bits)) >>> (32 - bits);
    endfunction

    function automatic void model_reset();
        mPC = 0;
        for (int i = 0; i < 32; i++) mR[i] = 0;
    endfunction

    function automatic void iss_step();
        logic [31:0] ins, a, b, res, npc;
        int op, rd, f3, rs1, rs2, f7;
        bit wr;
        ins = rom_m[mPC[5:2]];
        op = int'(ins & 32'h7f);       rd  = int'((ins >> 7) & 32'h1f);
        f3 = int'((ins >> 12) & 32'h7); rs1 = int'((ins >> 15) & 32'h1f);
        rs2 = int'((ins >> 20) & 32'h1f); f7 = int'(ins >> 25);
        a = mR[rs1]; b = mR[rs2];
        res = 0; wr = 0; npc = mPC + 4;
        if (op == 'h33) begin
            wr = 1;
            if (f7 == 0 && f3 == 0) res = a + b;
            else if (f7 == 'h20 && f3 == 0) res = a - b;
            else if (f7 == 0 && f3 == 7) res = a & b;
            else if (f7 == 0 && f3 == 6) res = a | b;
            else if (f7 == 0 && f3 == 4) res = a ^ b;
            else if (f7 == 0 && f3 == 2) res = (int'(a) < int'(b)) ? 1 : 0;
            else wr = 0;
        end else if (op == 'h13 && f3 == 0) begin
            wr = 1; res = a + sx(ins >> 20, 12);
        end else if (op == 'h03 && f3 == 2) begin
            wr = 1; res = mdm[((a + sx(ins >> 20, 12)) >> 2) % 16];
        end else if (op == 'h23 && f3 == 2) begin
            mdm[((a + sx(((ins >> 25) << 5) | ((ins >> 7) & 32'h1f), 12)) >> 2) % 16] = b;
        end else if (op == 'h6F) begin
            wr = 1; res = mPC + 4;
            npc = mPC + sx((((ins >> 31) & 1) << 20) | (((ins >> 12) & 32'hff) << 12)
                           | (((ins >> 20) & 1) << 11) | (((ins >> 21) & 32'h3ff) << 1), 21);
        end
        if (wr && rd != 0) mR[rd] = res;
        mPC = npc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".PC"}, dut.PC, mPC);
        chk({tag, ".IR"}, dut.IR, rom_m[mPC[5:2]]);
        for (int i = 0; i < 10; i++)
            chk($sformatf("%s.x%0d", tag, i), dut.R[i], mR[i]);
        chk({tag, ".leds"}, {29'h0, led_r, led_g, led_b}, {29'h0, mR[1][0], mR[2][0], mR[3][0]});
    endtask

    // Asynchronous reset asserted between clock edges; state must clear at once.
    task automatic do_reset();
        #($urandom_range(1, 3));
        RST = 1'b1;
        #1;
        model_reset();
        check_state("rst");
        chk("rst.slow_clk", {31'h0, dut.slow_clk}, 32'h0);
        repeat ($urandom_range(1, 3)) @(negedge CLK);
        RST = 1'b0;
    endtask

    // Called right after reset release at a negedge (SLOW_DIV = 2):
    // the first slow edge is 2 CLK edges later, then one every 4.
    task automatic run_edges(input int n);
        for (int k = 0; k < n; k++) begin
            repeat ((k == 0) ? 1 : 3) @(posedge CLK);
            #1;
            chk("pre.slow_clk", {31'h0, dut.slow_clk}, 32'h0);
            chk("pre.PC", dut.PC, mPC);
            @(posedge CLK);
            #1;
            iss_step();
            chk("edge.slow_clk", {31'h0, dut.slow_clk}, 32'h1);
            check_state($sformatf("e%0d", k + 1));
        end
    endtask

    initial begin
        build_rom();
        for (int i = 0; i < 16; i++) mdm[i] = 0;
        model_reset();

        // Power-on reset, then slow-clock timing of the SLOW_DIV=5 instance
        #2 RST = 1'b1;
        #1;
        check_state("por");
        @(negedge CLK) RST = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge CLK);
            #1;
            if (c == 4 || c == 14) chk($sformatf("div5.c%0d", c), {31'h0, dut5.slow_clk}, 32'h0);
            if (c == 5) begin
                chk("div5.c5", {31'h0, dut5.slow_clk}, 32'h1);
                chk("div5.pc5", dut5.PC, 32'd4);
            end
            if (c == 15) begin
                chk("div5.c15", {31'h0, dut5.slow_clk}, 32'h1);
                chk("div5.pc15", dut5.PC, 32'd8);
            end
        end

        // Full run from reset, well past the halt
        do_reset();
        run_edges(20);

        // Reset mid-program after edge 5, then at random points
        do_reset();
        run_edges(5);
        do_reset();
        repeat (2) begin
            run_edges($urandom_range(1, 12));
            do_reset();
        end
        run_edges(20);

        // Final state, written out directly from the expected program result
        chk("fin.x1", dut.R[1], 32'd5);
        chk("fin.x2", dut.R[2], 32'd3);
        chk("fin.x3", dut.R[3], 32'd8);
        chk("fin.x4", dut.R[4], 32'd0);
        chk("fin.x5", dut.R[5], 32'd9);
        chk("fin.x6", dut.R[6], 32'h2A);
        chk("fin.x8", dut.R[8], 32'h2A);
        chk("fin.x9", dut.R[9], 32'h2A);
        chk("fin.PC", dut.PC, 32'd40);
        chk("fin.IR", dut.IR, 32'h0000006F);
        chk("fin.dmem0", dut.r_dmem[0], 32'h2A);
        chk("fin.leds", {29'h0, led_r, led_g, led_b}, 32'b110);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
